xform_pipe: RTL
===============

Name: xform_pipe

Overview:
Parametrised, multi-stage data-transform register: the next generation of the team's clock-enabled invert register.
- Applies a selectable bit transform (pass, bit-reverse, rotate, half-swap) to each input word.
- Applies an optional inversion after the transform.
- Carries the result through DEPTH clock-enabled pipeline stages with valid tracking, synchronous flush and a saturating output-word counter.
- Sits between a data source and downstream logic that needs a fixed-latency, stallable transform path.

Parameters:
WIDTH, 16, data word width in bits; must be even and >= 2.
DEPTH, 2, number of pipeline stages; must be >= 1; latency in enabled cycles.
ROT, 1, rotate-left amount for mode 2; must be 0 <= ROT < WIDTH.
CNT_W, 8, width of the output-word counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rest  input  1  reset, asynchronous, active-low; asserted when 0.
ce  input  1  clock enable; 1 advances the pipeline, 0 holds all stages.
inv  input  1  1 = bitwise-invert the transformed word before stage 0.
mode  input  2  transform select: 00 pass, 01 bit-reverse, 10 rotate-left by ROT, 11 swap upper/lower halves.
flush  input  1  synchronous clear of all stage data and valid bits.
valid_in  input  1  data_in carries a valid word this cycle.
data_in  input  WIDTH  input word.
data_out  output  WIDTH  data of final stage.
valid_out  output  1  valid bit of final stage.
out_cnt  output  CNT_W  count of valid words that have entered the final stage; saturating.

Behaviour:
- Reset:
  - While rest=0, all stage data = 0, all stage valid = 0, data_out = 0, valid_out = 0, out_cnt = 0.
  - Reset takes effect immediately, independent of clk; mid-stream reset discards all in-flight words.
  - First update after release is the first rising edge with rest=1.
- Transform (combinational, on data_in):
  - Step 1, mode select:
    - mode 00: t = data_in.
    - mode 01: t[i] = data_in[WIDTH-1-i].
    - mode 10: t = rotate-left(data_in, ROT); ROT=0 equals pass.
    - mode 11: t = {data_in[WIDTH/2-1:0], data_in[WIDTH-1:WIDTH/2]}.
  - Step 2, inversion: x = inv ? ~t : t.
  - mode and inv are sampled at the same edge as data_in.
- Pipeline update, priority flush > ce > hold, per rising edge:
  - flush=1: every stage data <= 0 and valid <= 0, regardless of ce. valid_in is dropped; out_cnt is unchanged.
  - flush=0, ce=1:
    - Stage 0 <= (x, valid_in).
    - Stage k <= stage k-1 for k = 1..DEPTH-1.
    - Data is captured even when valid_in=0; only the valid bit qualifies it.
  - flush=0, ce=0: all stages hold; data_in, valid_in, mode and inv are ignored.
- Outputs:
  - data_out / valid_out = stage DEPTH-1, registered.
  - Latency is exactly DEPTH enabled edges from capture to data_out.
  - Stalled cycles do not count toward latency.
- out_cnt:
  - Increments by 1 on an edge with flush=0, ce=1 and a valid word moving into stage DEPTH-1. That valid source is stage DEPTH-2's valid bit, or valid_in when DEPTH=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by rest.
- Back-to-back valid words at full ce rate are supported with no bubbles.

Test Plan:
- Reset (WIDTH=16, DEPTH=2): drive rest=0 with data_in=0xF0F0, ce=1 and toggling clk -> data_out=0x0000, valid_out=0, out_cnt=0. Assert rest=0 asynchronously mid-stream -> outputs clear before the next clk edge.
- Pass and invert: mode=00, ce=1, valid_in=1, data_in=0xF0F0, inv=0 -> data_out=0xF0F0, valid_out=1 after 2 edges, out_cnt=1. Then inv=1, same data -> 0x0F0F one edge later, out_cnt=2.
- Modes:
  - mode=01, 0x0001 -> 0x8000.
  - mode=10, ROT=1, 0x8001 -> 0x0003.
  - mode=11, 0x12AB -> 0xAB12.
  - mode=11 with inv=1, 0x12AB -> 0x54ED.
  - Each checked at exactly 2-edge latency.
- Stall: load 0xAAAA, then ce=0 for 3 edges while data_in=0x5555 -> stage contents and out_cnt frozen. ce=1 -> 0xAAAA reaches data_out on the 2nd enabled edge; 0x5555 is never captured.
- Flush: two valid words in flight, flush=1 and ce=1 on one edge -> next cycle data_out=0x0000, valid_out=0, out_cnt unchanged; the word on data_in that edge is dropped.
- Saturation and bubbles: CNT_W=2, 5 valid words interleaved with valid_in=0 gaps -> valid_out low during gaps, out_cnt sequence 1,2,3,3,3.

Source files
------------

// File: rtl/xform_pipe.sv
// rtl/xform_pipe.sv - selectable bit transform with optional invert feeding a stallable, flushable pipeline
module xform_pipe #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int ROT   = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             ce,
    input  logic             inv,
    input  logic [1:0]       mode,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic [CNT_W-1:0] out_cnt
);

    logic [WIDTH-1:0] t_word;
    logic [WIDTH-1:0] x_word;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_valid;
    logic             last_src_valid;

    // Word transform selected by mode, then optional inversion ahead of stage 0
    always_comb begin
        t_word = data_in;
        case (mode)
            2'b01: begin
                for (int i = 0; i < WIDTH; i++) begin
                    t_word[i] = data_in[WIDTH-1-i];
                end
            end
            2'b10: begin
                for (int i = 0; i < WIDTH; i++) begin
                    t_word[(i + ROT) % WIDTH] = data_in[i];
                end
            end
            2'b11:   t_word = {data_in[WIDTH/2-1:0], data_in[WIDTH-1:WIDTH/2]};
            default: t_word = data_in;
        endcase
        x_word = inv ? ~t_word : t_word;
    end

    // The word about to enter the final stage comes straight from the input when there is only one stage
    if (DEPTH == 1) begin : g_src_in
        assign last_src_valid = valid_in;
    end else begin : g_src_stage
        assign last_src_valid = stage_valid[DEPTH-2];
    end

    // Pipeline stages: flush beats enable, enable beats hold; data moves even for invalid slots
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_data[k] <= '0;
            end
            stage_valid <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_data[k] <= '0;
            end
            stage_valid <= '0;
        end else if (ce) begin
            stage_data[0]  <= x_word;
            stage_valid[0] <= valid_in;
            for (int k = 1; k < DEPTH; k++) begin
                stage_data[k]  <= stage_data[k-1];
                stage_valid[k] <= stage_valid[k-1];
            end
        end
    end

    // Saturating count of valid words landing in the final stage; survives flush
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            out_cnt <= '0;
        end else if (!flush && ce && last_src_valid && (out_cnt != {CNT_W{1'b1}})) begin
            out_cnt <= out_cnt + 1'b1;
        end
    end

    assign data_out  = stage_data[DEPTH-1];
    assign valid_out = stage_valid[DEPTH-1];

endmodule
